bird_hit_ctrl: RTL and testbench
================================

# bird_hit_ctrl

Per-bird status controller that consumes the per-pixel drawing requests coming out of the bird drawer and the missile drawer, and produces that drawer's control inputs: `flash`, `alive` and `duty50`. Collisions are detected pixel-by-pixel, latched per frame, and resolved once per frame into a hit-point count, a flash (invulnerability) window and death. It sits between the object drawers and the bird drawer/score logic in the game top level.

## Interface
Parameters:
- `HIT_POINTS`, 3: hits a bird absorbs; the bird dies on the last one (range 1..15).
- `FLASH_FRAMES`, 8: frames of red flash / invulnerability after a non-fatal hit (range 1..255).
- `FLAP_FRAMES`, 16: frames between `duty50` toggles (range 1..255).

Ports:
- `clk`, input, 1: system clock; one clock for the block.
- `resetN`, input, 1: asynchronous, active-low reset.
- `startOfFrame`, input, 1: one-cycle pulse at the start of each video frame.
- `birdDrawingRequest`, input, 1: bird pixel is opaque at the current pixel.
- `missileDrawingRequest`, input, 1: player missile pixel is opaque at the current pixel.
- `respawn`, input, 1: one-cycle request to revive a dead bird.
- `flash`, output, 1: drive bird red.
- `alive`, output, 1: bird is alive.
- `duty50`, output, 1: wing phase, 1 = wings up.
- `hitPulse`, output, 1: one-cycle pulse per accepted non-fatal hit.
- `killPulse`, output, 1: one-cycle pulse when the bird dies.
- `hpLeft`, output, 4: remaining hit points.

## Operation
- Collision: `birdDrawingRequest && missileDrawingRequest && alive` in any cycle sets `hitLatch`.
- Frame resolution on `startOfFrame`: the value of `hitLatch` from before this cycle is evaluated, and the latch is then cleared. If a collision occurs in the same cycle as `startOfFrame`, the latch is set for the new frame.
- States:
  - ALIVE: on a latched hit, `hpLeft` decrements. If the new value is 0, go to DEAD, pulse `killPulse` and drop `alive`. Otherwise go to HIT, pulse `hitPulse`, set `flash` and load `flashCnt = FLASH_FRAMES`.
  - HIT: `flashCnt` decrements on each `startOfFrame`. Latched hits are discarded. When the count reaches 0 (on the `startOfFrame` that decrements it from 1), go to ALIVE and clear `flash`.
  - DEAD: `alive` = 0 and `flash` = 0. On `respawn`, go to ALIVE, set `hpLeft = HIT_POINTS`, clear `hitLatch` and reset the flap counter.
- `respawn` is ignored outside DEAD. If `respawn` and `startOfFrame` arrive together in DEAD, `respawn` wins and no hit is evaluated.
- Flap:
  - `flapCnt` counts frames while not DEAD.
  - When it reaches `FLAP_FRAMES - 1`, `duty50` toggles and the counter wraps to 0.
  - In DEAD, `duty50` and the counter are frozen.
- Widths: `hpLeft` is 4 bits; `flashCnt` and `flapCnt` are 8 bits. No counter wraps below 0.

## Timing
- Reset values:
  - State ALIVE.
  - `alive` = 1, `flash` = 0, `duty50` = 0.
  - `hitPulse` = 0, `killPulse` = 0.
  - `hpLeft` = `HIT_POINTS`.
  - `hitLatch`, `flashCnt` and `flapCnt` all 0.
- All outputs are registered.
- A hit processed on the `startOfFrame` edge shows up in `flash`, `alive`, `hpLeft` and the pulses on the next cycle, i.e. one cycle of latency.
- Pulses are exactly one cycle wide.
- Reset asserted mid-frame or mid-flash returns every register to its reset value immediately, independent of the clock.
- Back-to-back frames with hits during HIT cause no decrement.

## Structure
- Package `bird_pkg`:
  - Enum `bird_state_t` {ALIVE, HIT, DEAD}.
  - Default constants `BIRD_HIT_POINTS`, `BIRD_FLASH_FRAMES`, `BIRD_FLAP_FRAMES`.
  - The bird drawer shares these constants.
- One sub-module, `frame_tick_counter`:
  - Counts `startOfFrame` pulses and emits a terminal-count strobe.
  - Parameterised by a modulus, with enable and clear inputs.
  - Used for the flap timer; the flash counter stays inline because it is loaded and counts down.

## Test plan
- Reset, then 40 frames with no collisions → `alive` = 1, `flash` = 0, `hpLeft` = 3; `duty50` toggles on frames 16 and 32.
- Single-cycle collision mid-frame, then `startOfFrame` → next cycle `hitPulse` = 1 for one cycle, `hpLeft` = 2, `flash` = 1; `flash` clears after 8 frames.
- Collisions in every frame during the flash window → `hpLeft` stays 2, no `hitPulse`.
- Three hits spaced 10 frames apart → third resolution gives `killPulse` = 1, `alive` = 0, `hpLeft` = 0; `duty50` frozen and further collisions ignored.
- `respawn` together with `startOfFrame` while DEAD, with `hitLatch` set → ALIVE, `hpLeft` = 3, no hit counted.
- Collision in the same cycle as `startOfFrame` → not counted this frame, counted at the following `startOfFrame`; `resetN` low during HIT → all outputs return to reset values immediately.

Source files
------------

// File: rtl/bird_pkg.sv
// Shared state type and default tuning constants for the bird hit controller
// and the bird drawer.
package bird_pkg;

  typedef enum logic [1:0] {
    ALIVE,
    HIT,
    DEAD
  } bird_state_t;

  localparam int unsigned BIRD_HIT_POINTS   = 3;
  localparam int unsigned BIRD_FLASH_FRAMES = 8;
  localparam int unsigned BIRD_FLAP_FRAMES  = 16;

  localparam int unsigned HP_W  = 4;
  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/bird_hit_ctrl_if.sv
// Drawer-side signal bundle for one bird: pixel requests in, bird drawer
// controls and score events out.
interface bird_hit_ctrl_if;
  import bird_pkg::*;

  logic            startOfFrame;
  logic            birdDrawingRequest;
  logic            missileDrawingRequest;
  logic            respawn;
  logic            flash;
  logic            alive;
  logic            duty50;
  logic            hitPulse;
  logic            killPulse;
  logic [HP_W-1:0] hpLeft;

  modport master (
    output startOfFrame, birdDrawingRequest, missileDrawingRequest, respawn,
    input  flash, alive, duty50, hitPulse, killPulse, hpLeft
  );

  modport slave (
    input  startOfFrame, birdDrawingRequest, missileDrawingRequest, respawn,
    output flash, alive, duty50, hitPulse, killPulse, hpLeft
  );

endinterface

// File: rtl/frame_tick_counter.sv
// Modulo counter of frame ticks; wrap strobes combinationally on the tick that
// takes the count from MODULUS-1 back to 0.
module frame_tick_counter #(
  parameter int unsigned MODULUS = 16,
  parameter int unsigned WIDTH   = 8
) (
  input  logic clk,
  input  logic resetN,
  input  logic tick,
  input  logic enable,
  input  logic clear,
  output logic wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    wrap  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (tick && enable) begin
      if (cnt_q >= LAST) begin
        cnt_d = '0;
        wrap  = 1'b1;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bird_hit_ctrl.sv
// Per-bird status controller: latches missile collisions within a frame and
// resolves them at start of frame into hit points, flash window and death.
module bird_hit_ctrl
  import bird_pkg::*;
#(
  parameter int unsigned HIT_POINTS   = BIRD_HIT_POINTS,
  parameter int unsigned FLASH_FRAMES = BIRD_FLASH_FRAMES,
  parameter int unsigned FLAP_FRAMES  = BIRD_FLAP_FRAMES
) (
  input logic            clk,
  input logic            resetN,
  bird_hit_ctrl_if.slave bus
);

  localparam logic [HP_W-1:0]  HP_INIT    = HP_W'(HIT_POINTS);
  localparam logic [CNT_W-1:0] FLASH_INIT = CNT_W'(FLASH_FRAMES);

  bird_state_t      state_q, state_d;
  logic             hit_latch_q, hit_latch_d;
  logic [CNT_W-1:0] flash_cnt_q, flash_cnt_d;
  logic [HP_W-1:0]  hp_q, hp_d;
  logic             flash_q, flash_d;
  logic             alive_q, alive_d;
  logic             duty_q, duty_d;
  logic             hit_pulse_q, hit_pulse_d;
  logic             kill_pulse_q, kill_pulse_d;

  logic collision;
  logic revive;
  logic flap_wrap;

  assign collision = bus.birdDrawingRequest & bus.missileDrawingRequest & alive_q;
  assign revive    = (state_q == DEAD) & bus.respawn;

  frame_tick_counter #(
    .MODULUS (FLAP_FRAMES),
    .WIDTH   (CNT_W)
  ) u_flap_cnt (
    .clk    (clk),
    .resetN (resetN),
    .tick   (bus.startOfFrame),
    .enable (state_q != DEAD),
    .clear  (revive),
    .wrap   (flap_wrap)
  );

  always_comb begin
    state_d      = state_q;
    flash_cnt_d  = flash_cnt_q;
    hp_d         = hp_q;
    flash_d      = flash_q;
    alive_d      = alive_q;
    duty_d       = duty_q;
    hit_pulse_d  = 1'b0;
    kill_pulse_d = 1'b0;
    // Start of frame retires the old latch; a same-cycle collision belongs to the new frame.
    hit_latch_d  = bus.startOfFrame ? collision : (hit_latch_q | collision);

    if (flap_wrap) begin
      duty_d = ~duty_q;
    end

    unique case (state_q)
      ALIVE: begin
        if (bus.startOfFrame && hit_latch_q) begin
          hp_d = hp_q - HP_W'(1);
          if (hp_q == HP_W'(1)) begin
            state_d      = DEAD;
            alive_d      = 1'b0;
            flash_d      = 1'b0;
            kill_pulse_d = 1'b1;
          end else begin
            state_d     = HIT;
            flash_d     = 1'b1;
            flash_cnt_d = FLASH_INIT;
            hit_pulse_d = 1'b1;
          end
        end
      end
      HIT: begin
        // Latched hits are simply dropped while invulnerable.
        if (bus.startOfFrame) begin
          if (flash_cnt_q <= CNT_W'(1)) begin
            state_d     = ALIVE;
            flash_d     = 1'b0;
            flash_cnt_d = '0;
          end else begin
            flash_cnt_d = flash_cnt_q - CNT_W'(1);
          end
        end
      end
      DEAD: begin
        if (bus.respawn) begin
          state_d     = ALIVE;
          hp_d        = HP_INIT;
          alive_d     = 1'b1;
          flash_d     = 1'b0;
          hit_latch_d = 1'b0;
        end
      end
      default: begin
        state_d = ALIVE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= ALIVE;
      hit_latch_q  <= 1'b0;
      flash_cnt_q  <= '0;
      hp_q         <= HP_INIT;
      flash_q      <= 1'b0;
      alive_q      <= 1'b1;
      duty_q       <= 1'b0;
      hit_pulse_q  <= 1'b0;
      kill_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hit_latch_q  <= hit_latch_d;
      flash_cnt_q  <= flash_cnt_d;
      hp_q         <= hp_d;
      flash_q      <= flash_d;
      alive_q      <= alive_d;
      duty_q       <= duty_d;
      hit_pulse_q  <= hit_pulse_d;
      kill_pulse_q <= kill_pulse_d;
    end
  end

  assign bus.flash     = flash_q;
  assign bus.alive     = alive_q;
  assign bus.duty50    = duty_q;
  assign bus.hitPulse  = hit_pulse_q;
  assign bus.killPulse = kill_pulse_q;
  assign bus.hpLeft    = hp_q;

endmodule

// File: tb/tb_bird_hit_ctrl.sv
// Scoreboard bench for bird_hit_ctrl: a frame-level model queues the expected
// outputs per cycle and a monitor compares them after each rising edge.
module tb_bird_hit_ctrl;

  localparam int HP    = 3;
  localparam int FLASH = 8;
  localparam int FLAP  = 16;

  typedef struct packed {
    logic       flash;
    logic       alive;
    logic       duty;
    logic       hit;
    logic       kill;
    logic [3:0] hp;
  } outs_t;

  typedef struct {
    outs_t v;
    string tag;
  } exp_t;

  localparam outs_t RESET_OUTS = '{flash: 1'b0, alive: 1'b1, duty: 1'b0,
                                   hit: 1'b0, kill: 1'b0, hp: 4'd3};

  logic clk = 1'b0;
  logic resetN = 1'b0;

  bird_hit_ctrl_if bus ();

  bird_hit_ctrl #(
    .HIT_POINTS   (HP),
    .FLASH_FRAMES (FLASH),
    .FLAP_FRAMES  (FLAP)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  exp_t  exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  string phase = "reset";

  // Frame-level reference: hit points, frames of flash left, frames counted mod FLAP.
  int m_hp, m_flash_left, m_flap;
  bit m_dead, m_latch, m_duty, m_hitp, m_killp;

  function automatic void model_reset();
    m_hp = HP; m_flash_left = 0; m_flap = 0;
    m_dead = 0; m_latch = 0; m_duty = 0; m_hitp = 0; m_killp = 0;
  endfunction

  function automatic outs_t model_outs();
    outs_t o;
    o.flash = (m_flash_left > 0);
    o.alive = !m_dead;
    o.duty  = m_duty;
    o.hit   = m_hitp;
    o.kill  = m_killp;
    o.hp    = 4'(m_hp);
    return o;
  endfunction

  function automatic void model_step(input bit sof, input bit bird, input bit miss,
                                     input bit resp);
    bit coll;
    bit pend;
    coll    = bird && miss && !m_dead;
    pend    = m_latch;
    m_hitp  = 0;
    m_killp = 0;
    m_latch = sof ? coll : (m_latch | coll);
    if (m_dead && resp) begin
      m_dead = 0; m_hp = HP; m_latch = 0; m_flap = 0;
    end else if (sof) begin
      if (!m_dead) begin
        m_flap = (m_flap + 1) % FLAP;
        if (m_flap == 0) m_duty = !m_duty;
      end
      if (m_flash_left > 0) begin
        m_flash_left--;
      end else if (!m_dead && pend) begin
        m_hp--;
        if (m_hp == 0) begin
          m_dead = 1; m_killp = 1;
        end else begin
          m_flash_left = FLASH; m_hitp = 1;
        end
      end
    end
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o.flash = bus.flash;
    o.alive = bus.alive;
    o.duty  = bus.duty50;
    o.hit   = bus.hitPulse;
    o.kill  = bus.killPulse;
    o.hp    = bus.hpLeft;
    return o;
  endfunction

  task automatic compare(input string tag, input outs_t want);
    outs_t got;
    got = sample();
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @%0t: got flash=%b alive=%b duty=%b hit=%b kill=%b hp=%0d, want flash=%b alive=%b duty=%b hit=%b kill=%b hp=%0d",
               tag, $time, got.flash, got.alive, got.duty, got.hit, got.kill, got.hp,
               want.flash, want.alive, want.duty, want.hit, want.kill, want.hp);
    end
  endtask

  task automatic drive(input bit sof, input bit bird, input bit miss, input bit resp);
    exp_t e;
    @(negedge clk);
    bus.startOfFrame          = sof;
    bus.birdDrawingRequest    = bird;
    bus.missileDrawingRequest = miss;
    bus.respawn               = resp;
    if (resetN) model_step(sof, bird, miss, resp);
    e.v   = model_outs();
    e.tag = phase;
    exp_q.push_back(e);
  endtask

  // One frame: start pulse on cycle 0, collision only at hit_at, else bird/missile noise.
  task automatic frame(input int len, input int hit_at);
    bit b;
    bit m;
    for (int i = 0; i < len; i++) begin
      b = 1'($urandom_range(0, 1));
      m = b ? 1'b0 : 1'($urandom_range(0, 1));
      if (i == hit_at) begin
        b = 1'b1;
        m = 1'b1;
      end
      drive(i == 0, b, m, 1'b0);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare(e.tag, e.v);
      end
    end
  end

  initial begin : stimulus
    bus.startOfFrame          = 1'b0;
    bus.birdDrawingRequest    = 1'b0;
    bus.missileDrawingRequest = 1'b0;
    bus.respawn               = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    compare("reset_values", RESET_OUTS);
    @(negedge clk);
    resetN = 1'b1;

    phase = "idle_frames";
    drive(0, 0, 0, 1);
    repeat (40) frame(4, -1);

    phase = "hit_then_flash_window";
    frame(4, 2);
    repeat (8) frame(4, 2);
    repeat (3) frame(4, -1);

    phase = "kill_from_two";
    frame(4, 2);
    repeat (9) frame(4, -1);
    frame(4, 2);
    frame(4, -1);
    phase = "dead_frozen";
    repeat (20) frame(4, 2);
    drive(0, 0, 0, 1);
    repeat (2) frame(4, -1);

    phase = "three_hits";
    for (int k = 0; k < 2; k++) begin
      frame(4, 2);
      repeat (9) frame(4, -1);
    end
    frame(4, 2);
    drive(1, 1, 1, 0);
    drive(0, 0, 0, 0);
    drive(0, 1, 1, 0);
    phase = "respawn_with_sof";
    drive(1, 1, 1, 1);
    drive(0, 0, 0, 0);
    repeat (3) frame(4, -1);

    phase = "collision_on_sof";
    frame(4, 0);
    frame(4, -1);
    repeat (2) frame(4, -1);

    phase = "async_reset_in_hit";
    @(negedge clk);
    #2;
    resetN = 1'b0;
    #1;
    compare("async_reset", RESET_OUTS);
    model_reset();
    drive(1, 1, 1, 0);
    drive(0, 0, 0, 0);
    resetN = 1'b1;
    repeat (2) frame(4, -1);

    phase = "random";
    for (int f = 0; f < 200; f++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        drive(i == 0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 15) == 0));
      end
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
